// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter/sequencer for a shared single-port memory
//
// Purpose:
//   Grants one of two requesters (instruction fetch "i", data "d") per access,
//   holds the memory's level strobe (mem_r/mem_w) until mem_ready, captures read
//   data, pulses the granted requester's ready for one cycle, then returns to
//   IDLE so the memory always sees at least one strobe-low cycle between accesses.
//
// Configuration:
//   MEM_ARB_RR_EN  defined   -> round-robin on ties (port not last granted wins)
//                  undefined -> fixed priority, port d over port i
//
// Ports:
//   clk, rstn                      clock (rising edge), async active-low reset
//   i_req, i_addr                  instruction read request (level) and byte address
//   i_rdata, i_ready               instruction read word and one-cycle completion pulse
//   d_req_r, d_req_w               data read / write request (level); both high = write
//   d_addr, d_wdata                data byte address and write word
//   d_rdata, d_ready               data read word and one-cycle completion pulse
//   mem_r, mem_w                   memory read / write strobe (level)
//   mem_addr, mem_w_data           memory byte address and write word
//   mem_r_data, mem_ready          memory read word and completion pulse

module mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic [DATA_WIDTH-1:0] i_rdata,
   output logic                  i_ready,
   input  logic                  d_req_r,
   input  logic                  d_req_w,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  d_ready,
   output logic                  mem_r,
   output logic                  mem_w,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_w_data,
   input  logic [DATA_WIDTH-1:0] mem_r_data,
   input  logic                  mem_ready
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next;

   logic                  r_grant_d;     // 0 = port i, 1 = port d
   logic                  r_mem_r;
   logic                  r_mem_w;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_w_data;
   logic [DATA_WIDTH-1:0] r_i_rdata;
   logic [DATA_WIDTH-1:0] r_d_rdata;
   logic                  r_i_ready;
   logic                  r_d_ready;

   logic                  w_d_req;
   logic                  w_any_req;
   logic                  w_pick_d;
   logic                  w_start;
   logic                  w_done;

   assign w_d_req   = d_req_r | d_req_w;
   assign w_any_req = i_req | w_d_req;

`ifdef MEM_ARB_RR_EN
   // On a tie the port not recorded in the grant register wins; the grant
   // register resets to port i, so port d takes the first tie.
   assign w_pick_d = w_d_req & (~i_req | ~r_grant_d);
`else
   assign w_pick_d = w_d_req;
`endif

   assign w_start = (r_state == S_IDLE) & w_any_req;
   assign w_done  = (r_state == S_BUSY) & mem_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_any_req) w_next = S_BUSY;
         S_BUSY:  if (mem_ready) w_next = S_RESP;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_grant_d    <= 1'b0;
         r_mem_r      <= 1'b0;
         r_mem_w      <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_w_data <= '0;
         r_i_rdata    <= '0;
         r_d_rdata    <= '0;
         r_i_ready    <= 1'b0;
         r_d_ready    <= 1'b0;
      end else begin
         r_i_ready <= 1'b0;
         r_d_ready <= 1'b0;
         if (w_start) begin
            r_grant_d  <= w_pick_d;
            r_mem_addr <= w_pick_d ? d_addr : i_addr;
            if (w_pick_d) begin
               r_mem_w_data <= d_wdata;
            end
            // A simultaneous d read+write is a write; port i only reads.
            r_mem_w <= w_pick_d & d_req_w;
            r_mem_r <= ~(w_pick_d & d_req_w);
         end
         if (w_done) begin
            r_mem_r <= 1'b0;
            r_mem_w <= 1'b0;
            // r_mem_r still holds the latched op at this edge.
            if (r_mem_r) begin
               if (r_grant_d) begin
                  r_d_rdata <= mem_r_data;
               end else begin
                  r_i_rdata <= mem_r_data;
               end
            end
            r_d_ready <= r_grant_d;
            r_i_ready <= ~r_grant_d;
         end
      end
   end

   assign mem_r      = r_mem_r;
   assign mem_w      = r_mem_w;
   assign mem_addr   = r_mem_addr;
   assign mem_w_data = r_mem_w_data;
   assign i_rdata    = r_i_rdata;
   assign d_rdata    = r_d_rdata;
   assign i_ready    = r_i_ready;
   assign d_ready    = r_d_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter

module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rstn;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_ready;
   logic        d_req_r;
   logic        d_req_w;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic        mem_r;
   logic        mem_w;
   logic [31:0] mem_addr;
   logic [31:0] mem_w_data;
   logic [31:0] mem_r_data;
   logic        mem_ready;

   int checks   = 0;
   int failures = 0;

   mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .i_req      (i_req),
      .i_addr     (i_addr),
      .i_rdata    (i_rdata),
      .i_ready    (i_ready),
      .d_req_r    (d_req_r),
      .d_req_w    (d_req_w),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_rdata    (d_rdata),
      .d_ready    (d_ready),
      .mem_r      (mem_r),
      .mem_w      (mem_w),
      .mem_addr   (mem_addr),
      .mem_w_data (mem_w_data),
      .mem_r_data (mem_r_data),
      .mem_ready  (mem_ready)
   );

   always #5 clk = ~clk;

   // Memory model: counts strobe-high cycles, raises mem_ready for one cycle
   // after mem_lat+1 of them.
   logic [31:0] mem [64];
   logic [31:0] ref_mem [64];
   int          mem_lat = 4;
   int          cnt;
   logic        mrdy;
   logic        stray = 1'b0;
   logic [31:0] mrd;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt  <= 0;
         mrdy <= 1'b0;
         mrd  <= '0;
      end else if ((mem_r | mem_w) && !mrdy) begin
         if (cnt == mem_lat) begin
            mrdy <= 1'b1;
            mrd  <= mem[mem_addr[7:2]];
            if (mem_w) mem[mem_addr[7:2]] <= mem_w_data;
         end else begin
            cnt <= cnt + 1;
         end
      end else begin
         mrdy <= 1'b0;
         cnt  <= 0;
      end
   end

   assign mem_ready  = mrdy | stray;
   assign mem_r_data = mrdy ? mrd : 32'hxxxx_xxxx;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Ticks until a ready pulse (bounded); records strobe cycles and what the
   // memory saw. Optionally changes d_addr at cycle chg_cyc.
   task automatic access_wait(input int chg_cyc, input logic [31:0] chg_addr,
                              output int n, output int rd_c, output int wr_c,
                              output logic [31:0] addr_seen, output logic [31:0] wd_seen,
                              output logic stable);
      n = 0; rd_c = 0; wr_c = 0; stable = 1'b1;
      addr_seen = '0; wd_seen = '0;
      while (n < 60) begin
         tick();
         n++;
         if (n == chg_cyc) d_addr = chg_addr;
         if (mem_r | mem_w) begin
            if (rd_c + wr_c == 0) begin
               addr_seen = mem_addr;
               wd_seen   = mem_w_data;
            end else if (mem_addr !== addr_seen || mem_w_data !== wd_seen) begin
               stable = 1'b0;
            end
            if (mem_r) rd_c++;
            if (mem_w) wr_c++;
         end
         if (i_ready | d_ready) break;
      end
   endtask

   // Arbitration rule: lone requester wins; on a tie d wins (fixed) or the
   // port not granted last wins (round-robin).
   function automatic bit pick_d(bit ireq, bit dreq, bit last_d);
      if (!dreq) return 1'b0;
      if (!ireq) return 1'b1;
`ifdef MEM_ARB_RR_EN
      return !last_d;
`else
      return 1'b1;
`endif
   endfunction

   initial begin
      int          n, rc, wc;
      logic [31:0] as, ws;
      logic        st;
      bit          last_d, w1, wd, dwr, ip, dp;
      int          dop;
      logic [31:0] ia, da, dw, exp_i, exp_d;

      rstn = 1'b0; i_req = 1'b0; i_addr = '0; d_req_r = 1'b0; d_req_w = 1'b0;
      d_addr = '0; d_wdata = '0;
      for (int k = 0; k < 64; k++) begin
         ref_mem[k] = $urandom;
         mem[k]     = ref_mem[k];
      end
      ref_mem[4] = 32'hDEADBEEF;
      mem[4]     = 32'hDEADBEEF;
      repeat (2) tick();
      chk("reset_ctrl", {mem_r, mem_w, i_ready, d_ready}, 0);
      chk("reset_mem_regs", {mem_addr, mem_w_data}, 0);
      chk("reset_rdata", {i_rdata, d_rdata}, 0);
      rstn = 1'b1;
      tick();
      last_d = 1'b0;

      // Single i read
      i_req = 1'b1; i_addr = 32'h10;
      access_wait(0, 0, n, rc, wc, as, ws, st);
      i_req = 1'b0;
      chk("i_latency", n, 7);
      chk("i_ready_only", {i_ready, d_ready}, 2'b10);
      chk("i_rdata", i_rdata, 32'hDEADBEEF);
      chk("i_rd_cycles", rc, 6);
      chk("i_wr_cycles", wc, 0);
      chk("i_mem_addr", as, 32'h10);
      chk("resp_strobes_low", {mem_r, mem_w}, 0);
      exp_i = 32'hDEADBEEF; last_d = 1'b0;
      tick();
      chk("ready_one_cycle", {i_ready, d_ready}, 0);

      // d write then d read
      d_req_w = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
      access_wait(0, 0, n, rc, wc, as, ws, st);
      d_req_w = 1'b0;
      chk("dw_latency", n, 7);
      chk("dw_ready_only", {i_ready, d_ready}, 2'b01);
      chk("dw_wr_cycles", wc, 6);
      chk("dw_rd_cycles", rc, 0);
      chk("dw_wdata", ws, 32'h12345678);
      chk("dw_addr", as, 32'h40);
      chk("dw_rdata_unchanged", d_rdata, 0);
      ref_mem[16] = 32'h12345678; last_d = 1'b1;
      tick();
      chk("gap_strobes_low", {mem_r, mem_w}, 0);
      stray = 1'b1;
      tick();
      stray = 1'b0;
      chk("stray_ready_ignored", {mem_r, mem_w, i_ready, d_ready}, 0);
      tick();
      chk("stray_ready_ignored2", {mem_r, mem_w, i_ready, d_ready}, 0);
      d_req_r = 1'b1;
      access_wait(0, 0, n, rc, wc, as, ws, st);
      d_req_r = 1'b0;
      chk("dr_latency", n, 7);
      chk("dr_rdata", d_rdata, 32'h12345678);
      chk("dr_rd_cycles", rc, 6);
      chk("i_rdata_held", i_rdata, exp_i);
      exp_d = 32'h12345678; last_d = 1'b1;
      tick();

      // Simultaneous requests
      i_req = 1'b1; i_addr = 32'h10; d_req_r = 1'b1; d_addr = 32'h40;
      w1 = pick_d(1'b1, 1'b1, last_d);
      access_wait(0, 0, n, rc, wc, as, ws, st);
      chk("tie_first", {i_ready, d_ready}, w1 ? 2'b01 : 2'b10);
      chk("tie_first_lat", n, 7);
      if (w1) d_req_r = 1'b0; else i_req = 1'b0;
      access_wait(0, 0, n, rc, wc, as, ws, st);
      chk("tie_second", {i_ready, d_ready}, w1 ? 2'b10 : 2'b01);
      chk("tie_gap", n, 8);
      chk("tie_i_rdata", i_rdata, exp_i);
      chk("tie_d_rdata", d_rdata, exp_d);
      i_req = 1'b0; d_req_r = 1'b0; last_d = !w1;
      tick();

      // Both held continuously for four grants
      i_req = 1'b1; d_req_r = 1'b1;
      for (int k = 0; k < 4; k++) begin
         w1 = pick_d(1'b1, 1'b1, last_d);
         access_wait(0, 0, n, rc, wc, as, ws, st);
         chk("grant_order", {i_ready, d_ready}, w1 ? 2'b01 : 2'b10);
         chk("grant_spacing", n, (k == 0) ? 7 : 8);
         last_d = w1;
      end
      i_req = 1'b0; d_req_r = 1'b0;
      tick();

      // Address change while BUSY
      d_req_r = 1'b1; d_addr = 32'h40;
      access_wait(3, 32'h80, n, rc, wc, as, ws, st);
      d_req_r = 1'b0; d_addr = 32'h40;
      chk("busy_addr_stable", st, 1'b1);
      chk("busy_addr", as, 32'h40);
      chk("busy_rdata", d_rdata, 32'h12345678);
      chk("busy_latency", n, 7);
      last_d = 1'b1;
      tick();

      // Reset mid-operation
      i_req = 1'b1; i_addr = 32'h10;
      repeat (4) tick();
      chk("midop_strobe", mem_r, 1'b1);
      rstn = 1'b0;
      #1;
      chk("rst_async_outputs", {mem_r, mem_w, i_ready, d_ready}, 0);
      i_req = 1'b0;
      repeat (2) tick();
      chk("rst_no_ready", {mem_r, mem_w, i_ready, d_ready}, 0);
      chk("rst_rdata_clear", {i_rdata, d_rdata}, 0);
      rstn = 1'b1;
      last_d = 1'b0;
      tick();
      i_req = 1'b1; d_req_r = 1'b1; d_addr = 32'h40;
      w1 = pick_d(1'b1, 1'b1, last_d);
      access_wait(0, 0, n, rc, wc, as, ws, st);
      chk("post_rst_first", {i_ready, d_ready}, w1 ? 2'b01 : 2'b10);
      chk("post_rst_lat", n, 7);
      if (w1) d_req_r = 1'b0; else i_req = 1'b0;
      access_wait(0, 0, n, rc, wc, as, ws, st);
      chk("post_rst_second", n, 8);
      i_req = 1'b0; d_req_r = 1'b0;
      exp_i = 32'hDEADBEEF; exp_d = 32'h12345678; last_d = !w1;
      chk("post_rst_i_rdata", i_rdata, exp_i);
      chk("post_rst_d_rdata", d_rdata, exp_d);
      tick();

      // Randomized traffic against the reference model
      ip = 1'b0; dp = 1'b0; ia = '0; da = '0; dw = '0; dop = 0;
      for (int it = 0; it < 40; it++) begin
         if (!ip && $urandom_range(0, 1) == 1) begin
            ip = 1'b1;
            ia = 32'($urandom_range(0, 15)) << 2;
         end
         if (!dp && ($urandom_range(0, 1) == 1 || !ip)) begin
            dp  = 1'b1;
            da  = 32'($urandom_range(0, 15)) << 2;
            dw  = $urandom;
            dop = int'($urandom_range(0, 2));
         end
         mem_lat = int'($urandom_range(0, 5));
         i_req = ip; i_addr = ia;
         d_req_r = dp && dop != 1; d_req_w = dp && dop != 0;
         d_addr = da; d_wdata = dw;
         wd  = pick_d(ip, dp, last_d);
         dwr = wd && dop != 0;
         access_wait(0, 0, n, rc, wc, as, ws, st);
         chk("rnd_latency", n, mem_lat + 3);
         chk("rnd_port", {i_ready, d_ready}, wd ? 2'b01 : 2'b10);
         chk("rnd_addr", as, wd ? da : ia);
         chk("rnd_rd_cycles", rc, dwr ? 0 : mem_lat + 2);
         chk("rnd_wr_cycles", wc, dwr ? mem_lat + 2 : 0);
         if (dwr) begin
            chk("rnd_wdata", ws, dw);
            ref_mem[da[7:2]] = dw;
         end else if (wd) begin
            exp_d = ref_mem[da[7:2]];
         end else begin
            exp_i = ref_mem[ia[7:2]];
         end
         chk("rnd_i_rdata", i_rdata, exp_i);
         chk("rnd_d_rdata", d_rdata, exp_d);
         if (wd) begin
            dp = 1'b0; d_req_r = 1'b0; d_req_w = 1'b0;
         end else begin
            ip = 1'b0; i_req = 1'b0;
         end
         last_d = wd;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the shared single-port memory model.
- Requesters: the instruction fetch path (read-only, port "i") and the data path (read/write, port "d").
- Latches one request at a time and drives the memory's level-held mem_r/mem_w handshake until mem_ready.
- Captures the read word, returns a one-cycle ready pulse to the granted requester, then forces one idle cycle so the memory's latency counter restarts cleanly.

Parameters:
- ADDR_WIDTH, 32, byte-address width on all ports.
- DATA_WIDTH, 32, word width on all data ports.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- i_req  in  1  instruction read request; level, held until i_ready.
- i_addr  in  ADDR_WIDTH  instruction read byte address.
- i_rdata  out  DATA_WIDTH  instruction read data; valid while i_ready=1.
- i_ready  out  1  one-cycle completion pulse for port i.
- d_req_r  in  1  data read request; level, held until d_ready.
- d_req_w  in  1  data write request; level, held until d_ready.
- d_addr  in  ADDR_WIDTH  data byte address.
- d_wdata  in  DATA_WIDTH  data write word.
- d_rdata  out  DATA_WIDTH  data read word; valid while d_ready=1.
- d_ready  out  1  one-cycle completion pulse for port d.
- mem_r  out  1  memory read strobe; level.
- mem_w  out  1  memory write strobe; level.
- mem_addr  out  ADDR_WIDTH  memory byte address.
- mem_w_data  out  DATA_WIDTH  memory write word.
- mem_r_data  in  DATA_WIDTH  memory read word; valid only while mem_ready=1.
- mem_ready  in  1  memory completion pulse.

Behaviour:
- Reset values: FSM=IDLE; mem_r, mem_w, i_ready, d_ready = 0; mem_addr, mem_w_data, i_rdata, d_rdata = 0; grant register = port i.
- FSM states: IDLE, BUSY, RESP.
- IDLE, no request pending: stay in IDLE.
- IDLE, request pending: pick a winner. At the edge, latch the winner's address, write data and op; set the grant register; go to BUSY.
- BUSY: mem_r or mem_w is registered high and equals the latched op. mem_addr and mem_w_data are held constant.
- Requester inputs are ignored while in BUSY or RESP.
- BUSY, mem_ready=1: at that edge, capture mem_r_data into the granted port's rdata register (reads only), drop mem_r/mem_w, go to RESP.
- RESP: granted port's ready=1 for exactly one cycle; mem strobes are low. Next state is always IDLE, giving the memory at least one strobe-low cycle before the next access.
- Requester obligation: deassert the request in the cycle after its ready. A request still high in IDLE is treated as a new request.
- rdata registers hold their value until overwritten by the next read on the same port.
- On port d writes, d_rdata is unchanged.
- Arbitration (default): fixed priority, port d over port i.
- d_req_r and d_req_w both high: treated as a write; the read is dropped.
- Latency: request sampled in IDLE at cycle 0 → mem strobe high from cycle 1. If mem_ready arrives at cycle 1+L, requester ready is at cycle 2+L. With the memory's 4-count delay, L=5, so ready is at cycle 7.
- Throughput: at most one access per L+3 cycles.
- mem_ready seen outside BUSY: ignored.
- Reset mid-operation: returns to IDLE immediately. The in-flight access is abandoned and no ready pulse is produced. The memory shares rstn, so its counter also clears.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. When both ports request in IDLE, the port not recorded in the grant register wins. A lone requester always wins. After reset, port d wins the first tie.
- Undefined: fixed priority (d over i) as above; port i can starve under continuous port d traffic.

Test Plan:
- Single i read: i_req=1, i_addr=0x10, memory word 0x00000004 = 0xDEADBEEF → mem_r high cycles 1–6, mem_addr=0x10, i_ready pulses at cycle 7 with i_rdata=0xDEADBEEF; d_ready stays 0.
- d write then d read: write 0x12345678 to 0x40, then read 0x40 → mem_w high only during the first BUSY with mem_w_data=0x12345678; second access gives d_rdata=0x12345678; at least one cycle with mem_r=mem_w=0 between accesses.
- Simultaneous requests, macro off: i_req and d_req_r high together, held → d served first; i served next; i_ready exactly 8 cycles after d_ready.
- Simultaneous requests, MEM_ARB_RR_EN: both held continuously for 4 grants → grant order d, i, d, i.
- Input change while BUSY: change d_addr from 0x40 to 0x80 in cycle 3 → mem_addr stays 0x40 until RESP.
- Reset mid-op: pull rstn low in cycle 4 of a read → mem_r=0 and all ready outputs 0 immediately; after release, FSM is in IDLE and a new request completes normally.
